elevator_scan_ctrl: RTL and testbench

Parametrised multi-floor elevator controller and successor to the single-request elevator FSM. It latches any number of floor calls into a pending bitmask and serves them in SCAN order: continue in the current direction while calls remain ahead, otherwise reverse. It adds a door-open dwell and per-floor travel timing. The current floor feeds the existing 7-segment decoder; status bits go to the uo_out LEDs.

---
 rtl/elevator_pkg.sv | 38 +++
 rtl/cycle_timer.sv | 28 ++
 rtl/elevator_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller: state encoding,
// direction constants and pending-mask queries used by the FSM.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_e;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam int MAX_FLOORS = 16;

    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] mask,
                                         input int unsigned          pos);
        return ((32'(mask) >> (pos + 32'd1)) != 32'd0);
    endfunction

    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] mask,
                                         input int unsigned          pos);
        return ((32'(mask) & ((32'd1 << pos) - 32'd1)) != 32'd0);
    endfunction

    // Keep going while calls remain ahead, otherwise reverse, otherwise rest.
    function automatic state_e next_scan_state(input logic dir_up,
                                               input logic above,
                                               input logic below);
        if (dir_up == UP && above)   return ST_MOVE_UP;
        if (dir_up == DOWN && below) return ST_MOVE_DOWN;
        if (above)                   return ST_MOVE_UP;
        if (below)                   return ST_MOVE_DOWN;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_o pulses while enabled with the count at zero,
// so a load of N-1 expires N enabled cycles later.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    assign expired_o = en_i && (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Multi-floor SCAN elevator controller with door dwell and per-floor travel timing.
// Optional emergency stop input is enabled by defining ELEVATOR_ESTOP_EN.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 10,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 10000000,
    parameter int DOOR_CYCLES   = 20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop,
`endif
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  idle,
    output logic                  call_err
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_e                  state_q, state_d, nxt;
    logic [FLOOR_W-1:0]      floor_q, floor_d, arr_floor;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, pend_set, call_mask, arr_mask;
    logic                    dir_up_q, dir_up_d;
    logic                    call_err_q, call_err_d;
    logic                    frozen, in_range, call_ok, call_bad, here_call;
    logic                    timer_load, timer_en, timer_expired;
    logic [TW-1:0]           timer_val;

`ifdef ELEVATOR_ESTOP_EN
    assign frozen = estop;
`else
    assign frozen = 1'b0;
`endif

    assign in_range  = ({1'b0, call_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    assign call_ok   = call_valid && !frozen && in_range;
    assign call_bad  = call_valid && !frozen && !in_range;
    assign call_mask = call_ok ? (NUM_FLOORS'(1) << call_floor) : '0;
    // A call to the floor the car is parked at opens (or holds) the door instead of queuing.
    assign here_call = call_ok && (call_floor == floor_q) &&
                       (state_q == ST_IDLE || state_q == ST_DOOR_OPEN);
    assign pend_set  = pending_q | (here_call ? '0 : call_mask);

    assign arr_floor = (state_q == ST_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign arr_mask  = NUM_FLOORS'(1) << arr_floor;
    assign timer_en  = (state_q != ST_IDLE) && !frozen;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .en_i       (timer_en),
        .expired_o  (timer_expired)
    );

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch.
        state_d    = state_q;
        floor_d    = floor_q;
        dir_up_d   = dir_up_q;
        pending_d  = pend_set;
        call_err_d = call_err_q | call_bad;
        timer_load = 1'b0;
        timer_val  = TRAVEL_LOAD;
        nxt        = ST_IDLE;
        if (!frozen) begin
            unique case (state_q)
                ST_IDLE: begin
                    nxt = next_scan_state(UP, calls_above(MAX_FLOORS'(pending_q), 32'(floor_q)),
                                          calls_below(MAX_FLOORS'(pending_q), 32'(floor_q)));
                    if (here_call) begin
                        state_d    = ST_DOOR_OPEN;
                        timer_load = 1'b1;
                        timer_val  = DOOR_LOAD;
                    end else if (nxt != ST_IDLE) begin
                        state_d    = nxt;
                        dir_up_d   = (nxt == ST_MOVE_UP);
                        timer_load = 1'b1;
                    end
                end
                ST_MOVE_UP, ST_MOVE_DOWN: begin
                    if (timer_expired) begin
                        floor_d    = arr_floor;
                        timer_load = 1'b1;
                        // The clear beats a same-edge call to the arrival floor.
                        if (|(pend_set & arr_mask)) begin
                            pending_d = pend_set & ~arr_mask;
                            state_d   = ST_DOOR_OPEN;
                            timer_val = DOOR_LOAD;
                        end else begin
                            nxt = next_scan_state(dir_up_q,
                                      calls_above(MAX_FLOORS'(pend_set), 32'(arr_floor)),
                                      calls_below(MAX_FLOORS'(pend_set), 32'(arr_floor)));
                            state_d = nxt;
                            if (nxt != ST_IDLE) dir_up_d = (nxt == ST_MOVE_UP);
                        end
                    end
                end
                ST_DOOR_OPEN: begin
                    if (here_call) begin
                        timer_load = 1'b1;
                        timer_val  = DOOR_LOAD;
                    end else if (timer_expired) begin
                        nxt = next_scan_state(dir_up_q,
                                  calls_above(MAX_FLOORS'(pend_set), 32'(floor_q)),
                                  calls_below(MAX_FLOORS'(pend_set), 32'(floor_q)));
                        state_d    = nxt;
                        timer_load = 1'b1;
                        if (nxt != ST_IDLE) dir_up_d = (nxt == ST_MOVE_UP);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            floor_q    <= '0;
            pending_q  <= '0;
            dir_up_q   <= UP;
            call_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            pending_q  <= pending_d;
            dir_up_q   <= dir_up_d;
            call_err_q <= call_err_d;
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign moving        = (state_q == ST_MOVE_UP || state_q == ST_MOVE_DOWN) && !frozen;
    assign dir_up        = dir_up_q;
    assign door_open     = (state_q == ST_DOOR_OPEN);
    assign idle          = (state_q == ST_IDLE);
    assign call_err      = call_err_q;

    a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == ST_MOVE_DOWN) && (floor_q == '0)) &&
        !((state_q == ST_MOVE_UP) && (floor_q == TOP_FLOOR)));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with 6 floors, 4-cycle travel, 3-cycle door;
// covers ELEVATOR_ESTOP_EN when that macro is defined.
module tb_elevator_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       call_valid = 1'b0;
    logic [3:0] call_floor = 4'd0;
`ifdef ELEVATOR_ESTOP_EN
    logic       estop = 1'b0;
`endif
    logic [3:0] current_floor;
    logic [5:0] pending;
    logic       moving, dir_up, door_open, idle, call_err;

    int total = 0;
    int bad   = 0;

    elevator_scan_ctrl #(
        .NUM_FLOORS    (6),
        .FLOOR_W       (4),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
`ifdef ELEVATOR_ESTOP_EN
        .estop         (estop),
`endif
        .current_floor (current_floor),
        .pending       (pending),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .idle          (idle),
        .call_err      (call_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
            $error("%s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic call(input logic [3:0] f);
        call_valid = 1'b1;
        call_floor = f;
        tick();
        call_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_floor"}, 32'(current_floor), 32'd0);
        check({tag, "_pend"},  32'(pending),       32'd0);
        check({tag, "_idle"},  32'(idle),          32'd1);
        check({tag, "_mov"},   32'(moving),        32'd0);
        check({tag, "_door"},  32'(door_open),     32'd0);
        check({tag, "_dir"},   32'(dir_up),        32'd1);
        check({tag, "_err"},   32'(call_err),      32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        call_valid = 1'b0;
        call_floor = 4'd0;
`ifdef ELEVATOR_ESTOP_EN
        estop      = 1'b0;
`endif
        ticks(2);
        check_reset(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: single call to floor 3 from reset.
        do_reset("rst1");
        call(4'd3);
        check("t1_pend",  32'(pending), 32'd8);
        check("t1_idle",  32'(idle),    32'd1);
        tick();
        check("t1_mov",   32'(moving),  32'd1);
        check("t1_dir",   32'(dir_up),  32'd1);
        ticks(3);
        check("t1_f0",    32'(current_floor), 32'd0);
        tick();
        check("t1_f1",    32'(current_floor), 32'd1);
        ticks(4);
        check("t1_f2",    32'(current_floor), 32'd2);
        check("t1_mov2",  32'(moving),        32'd1);
        ticks(4);
        check("t1_f3",    32'(current_floor), 32'd3);
        check("t1_door",  32'(door_open),     32'd1);
        check("t1_pend0", 32'(pending),       32'd0);
        ticks(2);
        check("t1_door3", 32'(door_open),     32'd1);
        tick();
        check("t1_idle2", 32'(idle),          32'd1);
        check("t1_pendf", 32'(pending),       32'd0);

        // Test 2: calls 4 then 2 from floor 0; stop at 2 first, then 4.
        do_reset("rst2");
        call(4'd4);
        call(4'd2);
        check("t2_mov",    32'(moving),  32'd1);
        check("t2_pend",   32'(pending), 32'd20);
        ticks(8);
        check("t2_f2",     32'(current_floor), 32'd2);
        check("t2_door2",  32'(door_open),     32'd1);
        check("t2_pend2",  32'(pending),       32'd16);
        check("t2_dir2",   32'(dir_up),        32'd1);
        ticks(3);
        check("t2_mov2",   32'(moving),        32'd1);
        ticks(8);
        check("t2_f4",     32'(current_floor), 32'd4);
        check("t2_door4",  32'(door_open),     32'd1);
        check("t2_pend4",  32'(pending),       32'd0);
        check("t2_dir4",   32'(dir_up),        32'd1);
        ticks(3);
        check("t2_idle",   32'(idle),          32'd1);

        // Test 3: moving up to 5, call 1 arrives mid-trip; serve 5 then reverse.
        do_reset("rst3");
        call(4'd5);
        tick();
        check("t3_mov",    32'(moving),        32'd1);
        ticks(12);
        check("t3_f3",     32'(current_floor), 32'd3);
        call(4'd1);
        call(4'd5);
        check("t3_pend",   32'(pending),       32'd34);
        ticks(6);
        check("t3_f5",     32'(current_floor), 32'd5);
        check("t3_door5",  32'(door_open),     32'd1);
        check("t3_pend5",  32'(pending),       32'd2);
        ticks(3);
        check("t3_rev",    32'(moving),        32'd1);
        check("t3_dir",    32'(dir_up),        32'd0);
        check("t3_frev",   32'(current_floor), 32'd5);
        ticks(16);
        check("t3_f1",     32'(current_floor), 32'd1);
        check("t3_door1",  32'(door_open),     32'd1);
        check("t3_pend1",  32'(pending),       32'd0);
        ticks(3);
        check("t3_idle",   32'(idle),          32'd1);
        check("t3_dir_i",  32'(dir_up),        32'd0);

        // Test 4: idle at 2, call 2 opens door; repeat call restarts dwell.
        do_reset("rst4");
        call(4'd2);
        ticks(12);
        check("t4_idle",   32'(idle),          32'd1);
        check("t4_f2",     32'(current_floor), 32'd2);
        call(4'd2);
        check("t4_door",   32'(door_open),     32'd1);
        check("t4_pend",   32'(pending),       32'd0);
        tick();
        check("t4_door_c2", 32'(door_open),    32'd1);
        call(4'd2);
        check("t4_pend_r", 32'(pending),       32'd0);
        tick();
        check("t4_ext1",   32'(door_open),     32'd1);
        tick();
        check("t4_ext2",   32'(door_open),     32'd1);
        tick();
        check("t4_idle2",  32'(idle),          32'd1);

        // Test 5: out-of-range calls set sticky call_err.
        call(4'd7);
        check("t5_err",    32'(call_err),      32'd1);
        check("t5_pend",   32'(pending),       32'd0);
        check("t5_idle",   32'(idle),          32'd1);
        call(4'd7);
        check("t5_err2",   32'(call_err),      32'd1);
        tick();
        check("t5_err3",   32'(call_err),      32'd1);
        do_reset("rst5");
        call(4'd6);
        check("t5_err6",   32'(call_err),      32'd1);
        check("t5_pend6",  32'(pending),       32'd0);
        call(4'd5);
        check("t5_pend5",  32'(pending),       32'd32);
        check("t5_err5",   32'(call_err),      32'd1);

        // Test 6: asynchronous reset between floors 1 and 2.
        do_reset("rst6");
        call(4'd3);
        ticks(7);
        check("t6_f1",     32'(current_floor), 32'd1);
        check("t6_mov",    32'(moving),        32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_floor",  32'(current_floor), 32'd0);
        check("t6_pend",   32'(pending),       32'd0);
        check("t6_idle",   32'(idle),          32'd1);
        check("t6_mov0",   32'(moving),        32'd0);
        tick();
        rst_n = 1'b1;

`ifdef ELEVATOR_ESTOP_EN
        // Test 7: 10-cycle estop during travel delays arrival by 10 cycles.
        do_reset("rst7");
        call(4'd2);
        ticks(2);
        estop = 1'b1;
        tick();
        check("t7_mov0",   32'(moving),        32'd0);
        call(4'd7);
        check("t7_err",    32'(call_err),      32'd0);
        call(4'd4);
        check("t7_pend",   32'(pending),       32'd4);
        ticks(7);
        estop = 1'b0;
        ticks(2);
        check("t7_f0",     32'(current_floor), 32'd0);
        check("t7_mov1",   32'(moving),        32'd1);
        tick();
        check("t7_f1",     32'(current_floor), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
